move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//   Sequences all commands into the 2048 game datapath. Arbitrates button presses and an autoplay requester into a
//   small move FIFO and replays moves to game_logic as spaced one-cycle pulses. Also serialises host debug grid
//   writes so they never land while a move is in flight. Sits between input conditioning/host port and game_logic.
// PARAMETERS
//   FIFO_DEPTH  4   move queue entries; power of 2, >=2
//   GAP_CYCLES  16  idle cycles after a move pulse before next command; >=8 (covers transpose+4 rows+transpose+tile)
// PORTS
//   clk             in   1  clock
//   rst_n           in   1  synchronous active-low reset
//   btn_up/right/down/left in 1 each  debounced player buttons, level
//   auto_enable     in   1  autoplay requester allowed
//   auto_valid      in   1  autoplay move request
//   auto_dir        in   2  0=left 1=right 2=up 3=down
//   auto_ready      out  1  autoplay request accepted this cycle when high with auto_valid
//   dbg_wr_valid    in   1  host grid write request
//   dbg_wr_addr     in   4  cell index
//   dbg_wr_data     in   4  tile exponent
//   dbg_wr_ready    out  1  host write accepted when high with dbg_wr_valid
//   flush           in   1  discard all queued moves
//   clr_overflow    in   1  clear overflow flag
//   move_up/right/down/left out 1 each  one-hot, one-cycle move pulse to game_logic
//   debug_grid_valid out 1  one-cycle grid write strobe to game_logic
//   debug_grid_addr out  4  held with strobe
//   debug_grid_data out  4  held with strobe
//   queue_count     out  $clog2(FIFO_DEPTH)+1  moves queued
//   overflow        out  1  sticky: a button move was dropped
// BEHAVIOUR
//   Reset: all outputs 0, queue empty, FSM IDLE, button history 0; in-flight pulse/wait aborted.
//   Button events: per-button rising edge vs last cycle. Several edges same cycle -> one event,
//     priority left>right>up>down. Event pushes its direction.
//   Push arbitration: button event wins. auto_ready = auto_enable & ~button_event & ~flush & (space available).
//     Space available = count<FIFO_DEPTH, or a pop happens this cycle.
//   Full + button event with no pop: event dropped; overflow<=1 next cycle. clr_overflow clears; set wins if same cycle.
//   flush: empties queue same cycle; pushes and pops that cycle ignored; current WAIT continues.
//   FSM: IDLE, MOVE, WAIT, DBG.
//     IDLE, cycle T: dbg_wr_ready=1 (only in IDLE). dbg_wr_valid -> latch addr/data, go DBG
//       (debug has priority over moves). Else queue non-empty & ~flush -> pop head, go MOVE. Else stay.
//     DBG (T+1): debug_grid_valid=1 with latched addr/data; next IDLE. Back-to-back host writes: every 2 cycles.
//     MOVE (T+1): exactly one move_* high for the popped direction; load counter=GAP_CYCLES-1; next WAIT.
//     WAIT: decrement each cycle; at 0 go IDLE.
//       Pulse-to-pulse minimum = GAP_CYCLES+2 cycles. move_* low outside MOVE, so game_logic edge detect
//       sees each pulse as a new press.
//   FIFO: circular, pointers wrap mod FIFO_DEPTH. Order preserved FIFO. Push+pop same cycle at full or
//     empty-with-pop-ineligible resolved per rules above; count never exceeds FIFO_DEPTH nor underflows.
//   Ports with register outputs: move_*, debug_grid_*, overflow, queue_count registered; ready outputs combinational.
// TESTING
//   1 Reset, pulse btn_left 1 cycle -> queue_count 1 next cycle; move_left high 1 cycle at 2 cycles after press; no other move_*.
//   2 btn_right+btn_up rise same cycle -> single right move queued; count 1, no up move.
//   3 Five distinct presses while WAIT (depth 4) -> 4 queued, overflow=1; moves replay in press order,
//     pulses GAP_CYCLES+2 apart; clr_overflow -> 0.
//   4 dbg_wr_valid during WAIT -> ready low until IDLE; then ready high, debug_grid_valid at T+1 with addr 5 data 3;
//     a queued move issues after it.
//   5 auto_enable, auto_valid with dir 3, plus button edge same cycle -> auto_ready 0 that cycle; auto accepted next, down queued after button move.
//   6 rst_n low during MOVE/WAIT with 3 queued -> next cycle all outputs 0, count 0; flush empties queue without aborting WAIT.

Source files
------------

// File: rtl/move_scheduler.sv
// move_scheduler
//   Sequences every command into the 2048 game datapath. Player button edges
//   and autoplay requests are arbitrated into a small circular move queue;
//   moves are replayed to game_logic as spaced one-cycle pulses. Host debug
//   grid writes are serialised so they never land while a move is in flight.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   i_btn_up/right/down/left    debounced player buttons (level)
//   i_auto_enable/valid/dir     autoplay requester; o_auto_ready accepts
//   i_dbg_wr_valid/addr/data    host grid write; o_dbg_wr_ready accepts
//   i_flush                     discard all queued moves
//   i_clr_overflow              clear sticky overflow flag
//   o_move_up/right/down/left   one-hot single-cycle move pulse
//   o_debug_grid_valid/addr/data  single-cycle grid write strobe
//   o_queue_count               moves currently queued
//   o_overflow                  sticky: a button move was dropped
//
// Direction code used internally: 0=left 1=right 2=up 3=down.
//
// state  | meaning
// S_IDLE | accept host write or pop next move
// S_MOVE | move pulse on o_move_*, gap timer loaded
// S_WAIT | gap timer counting down to 0
// S_DBG  | debug grid strobe on o_debug_grid_*
module move_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_btn_up,
  input  logic                          i_btn_right,
  input  logic                          i_btn_down,
  input  logic                          i_btn_left,
  input  logic                          i_auto_enable,
  input  logic                          i_auto_valid,
  input  logic [1:0]                    i_auto_dir,
  output logic                          o_auto_ready,
  input  logic                          i_dbg_wr_valid,
  input  logic [3:0]                    i_dbg_wr_addr,
  input  logic [3:0]                    i_dbg_wr_data,
  output logic                          o_dbg_wr_ready,
  input  logic                          i_flush,
  input  logic                          i_clr_overflow,
  output logic                          o_move_up,
  output logic                          o_move_right,
  output logic                          o_move_down,
  output logic                          o_move_left,
  output logic                          o_debug_grid_valid,
  output logic [3:0]                    o_debug_grid_addr,
  output logic [3:0]                    o_debug_grid_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_queue_count,
  output logic                          o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_WAIT, S_DBG} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_btn_hist;
  logic [1:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_gap;
  logic [3:0]      r_move;
  logic            r_dbg_valid;
  logic [3:0]      r_dbg_addr;
  logic [3:0]      r_dbg_data;
  logic            r_overflow;

  logic [3:0]      w_btn;
  logic [3:0]      w_btn_rise;
  logic            w_btn_event;
  logic [1:0]      w_btn_dir;
  logic            w_full;
  logic            w_pop;
  logic            w_space;
  logic            w_push;
  logic [1:0]      w_push_dir;
  logic            w_drop;
  logic [1:0]      w_head;

  // Packed so that the bit index equals the direction code.
  assign w_btn       = {i_btn_down, i_btn_up, i_btn_right, i_btn_left};
  assign w_btn_rise  = w_btn & ~r_btn_hist;
  assign w_btn_event = |w_btn_rise;

  // Simultaneous edges collapse to one event: left > right > up > down.
  always_comb begin
    w_btn_dir = 2'd3;
    if (w_btn_rise[0])      w_btn_dir = 2'd0;
    else if (w_btn_rise[1]) w_btn_dir = 2'd1;
    else if (w_btn_rise[2]) w_btn_dir = 2'd2;
  end

  assign w_head  = r_fifo[r_rd_ptr];
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  // Host writes take priority over moves when both are pending in IDLE.
  assign w_pop   = (r_state == S_IDLE) & ~i_dbg_wr_valid & (r_count != '0) & ~i_flush;
  // A pop in the same cycle frees the slot a push needs.
  assign w_space = ~w_full | w_pop;

  assign o_auto_ready   = i_auto_enable & ~w_btn_event & ~i_flush & w_space;
  assign o_dbg_wr_ready = (r_state == S_IDLE);

  assign w_push     = ~i_flush & ((w_btn_event & w_space) | (o_auto_ready & i_auto_valid));
  assign w_push_dir = w_btn_event ? w_btn_dir : i_auto_dir;
  assign w_drop     = w_btn_event & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_btn_hist <= '0;
    else        r_btn_hist <= w_btn;
  end

  // Queue storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_dir;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (i_clr_overflow) r_overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_dbg_wr_valid) w_next = S_DBG;
        else if (w_pop)     w_next = S_MOVE;
      end
      S_MOVE:  w_next = S_WAIT;
      S_WAIT:  if (r_gap == '0) w_next = S_IDLE;
      S_DBG:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gap timer: loaded during the pulse, terminal count at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_gap <= '0;
    else if (r_state == S_MOVE)                r_gap <= TW'(GAP_CYCLES - 1);
    else if (r_state == S_WAIT && r_gap != '0) r_gap <= r_gap - TW'(1);
  end

  // Outputs are registered so they line up exactly with MOVE / DBG.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_move      <= '0;
      r_dbg_valid <= 1'b0;
      r_dbg_addr  <= '0;
      r_dbg_data  <= '0;
    end else begin
      r_move      <= (w_next == S_MOVE) ? (4'b0001 << w_head) : 4'b0000;
      r_dbg_valid <= (w_next == S_DBG);
      if (r_state == S_IDLE && i_dbg_wr_valid) begin
        r_dbg_addr <= i_dbg_wr_addr;
        r_dbg_data <= i_dbg_wr_data;
      end
    end
  end

  assign o_move_left        = r_move[0];
  assign o_move_right       = r_move[1];
  assign o_move_up          = r_move[2];
  assign o_move_down        = r_move[3];
  assign o_debug_grid_valid = r_dbg_valid;
  assign o_debug_grid_addr  = r_dbg_addr;
  assign o_debug_grid_data  = r_dbg_data;
  assign o_queue_count      = r_count;
  assign o_overflow         = r_overflow;

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_right, btn_down, btn_left;
  logic       auto_enable, auto_valid;
  logic [1:0] auto_dir;
  logic       auto_ready;
  logic       dbg_wr_valid;
  logic [3:0] dbg_wr_addr, dbg_wr_data;
  logic       dbg_wr_ready;
  logic       flush, clr_overflow;
  logic       move_up, move_right, move_down, move_left;
  logic       dbg_valid;
  logic [3:0] dbg_addr, dbg_data;
  logic [2:0] queue_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_moves[$];
  int pulse_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  move_scheduler #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_up(btn_up), .i_btn_right(btn_right), .i_btn_down(btn_down), .i_btn_left(btn_left),
    .i_auto_enable(auto_enable), .i_auto_valid(auto_valid), .i_auto_dir(auto_dir),
    .o_auto_ready(auto_ready),
    .i_dbg_wr_valid(dbg_wr_valid), .i_dbg_wr_addr(dbg_wr_addr), .i_dbg_wr_data(dbg_wr_data),
    .o_dbg_wr_ready(dbg_wr_ready),
    .i_flush(flush), .i_clr_overflow(clr_overflow),
    .o_move_up(move_up), .o_move_right(move_right), .o_move_down(move_down), .o_move_left(move_left),
    .o_debug_grid_valid(dbg_valid), .o_debug_grid_addr(dbg_addr), .o_debug_grid_data(dbg_data),
    .o_queue_count(queue_count), .o_overflow(overflow)
  );

  function automatic logic [3:0] mv_vec();
    return {move_down, move_up, move_right, move_left};
  endfunction

  // Scoreboard consumer: every move pulse is popped against the expected queue.
  always @(negedge clk) begin
    logic [3:0] mv;
    int got;
    int e;
    mv = {move_down, move_up, move_right, move_left};
    if (mv != 4'b0000) begin
      checks++;
      got = mv[0] ? 0 : mv[1] ? 1 : mv[2] ? 2 : 3;
      pulse_cyc.push_back(cyc);
      if ($countones(mv) != 1) begin
        errors++;
        $display("FAIL move_onehot: got %b, required exactly one bit", mv);
      end else if (exp_moves.size() == 0) begin
        errors++;
        $display("FAIL move_unexpected: got dir %0d, required no move", got);
      end else begin
        e = exp_moves.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL move_order: got dir %0d, required dir %0d", got, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0: btn_left  = v;
      1: btn_right = v;
      2: btn_up    = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int d);
    exp_moves.push_back(d);
    set_btn(d, 1'b1);
    step();
    set_btn(d, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (dbg_wr_ready === 1'b1 && queue_count === 3'd0) begin
        ok = 1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got count %0d ready %b, required idle empty within 200 cycles",
               name, queue_count, dbg_wr_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", queue_count); end
    checks++; if (mv_vec() !== 4'b0000) begin errors++; $display("FAIL reset_moves: got %b required 0000", mv_vec()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    checks++; if (dbg_valid !== 1'b0 || dbg_addr !== 4'd0 || dbg_data !== 4'd0) begin
      errors++; $display("FAIL reset_dbg: got v=%b a=%0d d=%0d required 0", dbg_valid, dbg_addr, dbg_data); end
    checks++; if (dbg_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_dbg_ready: got %b required 1", dbg_wr_ready); end
    checks++; if (auto_ready !== 1'b0) begin errors++; $display("FAIL reset_auto_ready: got %b required 0", auto_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_press();
    press(0);
    checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d required 1", queue_count); end
    checks++; if (mv_vec() !== 4'b0000) begin errors++; $display("FAIL single_early: got %b required 0000", mv_vec()); end
    step();
    checks++; if (mv_vec() !== 4'b0001) begin errors++; $display("FAIL single_pulse: got %b required 0001", mv_vec()); end
    step();
    checks++; if (mv_vec() !== 4'b0000) begin errors++; $display("FAIL single_width: got %b required 0000", mv_vec()); end
    wait_idle("single");
  endtask

  task automatic test_priority();
    exp_moves.push_back(1);
    btn_right = 1'b1;
    btn_up    = 1'b1;
    step();
    btn_right = 1'b0;
    btn_up    = 1'b0;
    checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL prio_count: got %0d required 1", queue_count); end
    step();
    checks++; if (mv_vec() !== 4'b0010) begin errors++; $display("FAIL prio_pulse: got %b required 0010", mv_vec()); end
    wait_idle("prio");
  endtask

  task automatic test_overflow();
    int seq[5] = '{1, 2, 3, 0, 1};
    pulse_cyc.delete();
    press(0);
    step();               // MOVE
    step();               // WAIT
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_moves.push_back(seq[i]);
      set_btn(seq[i], 1'b1);
      step();
      set_btn(seq[i], 1'b0);
      step();
    end
    checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d required 4", queue_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    wait_idle("ovf");
    checks++;
    if (pulse_cyc.size() != 5) begin
      errors++; $display("FAIL ovf_pulses: got %0d pulses required 5", pulse_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (pulse_cyc[i] - pulse_cyc[i-1] != GAP + 2) begin
          errors++;
          $display("FAIL ovf_gap%0d: got %0d cycles required %0d", i, pulse_cyc[i] - pulse_cyc[i-1], GAP + 2);
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
  endtask

  task automatic test_dbg_during_wait();
    bit found = 0;
    press(2);
    step();               // MOVE
    step();               // WAIT
    press(3);
    step();
    dbg_wr_valid = 1'b1;
    dbg_wr_addr  = 4'd5;
    dbg_wr_data  = 4'd3;
    checks++; if (dbg_wr_ready !== 1'b0) begin errors++; $display("FAIL dbg_ready_wait: got %b required 0", dbg_wr_ready); end
    for (int i = 0; i < 40; i++) begin
      if (dbg_wr_ready === 1'b1) begin
        found = 1;
        break;
      end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL dbg_ready_timeout: got 0 required 1 within 40 cycles"); end
    step();
    dbg_wr_valid = 1'b0;
    checks++; if (dbg_valid !== 1'b1 || dbg_addr !== 4'd5 || dbg_data !== 4'd3) begin
      errors++; $display("FAIL dbg_strobe: got v=%b a=%0d d=%0d required v=1 a=5 d=3", dbg_valid, dbg_addr, dbg_data); end
    checks++; if (queue_count !== 3'd1 || mv_vec() !== 4'b0000) begin
      errors++; $display("FAIL dbg_priority: got count %0d moves %b required 1 0000", queue_count, mv_vec()); end
    step();
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL dbg_width: got %b required 0", dbg_valid); end
    step();
    checks++; if (mv_vec() !== 4'b1000) begin errors++; $display("FAIL dbg_then_move: got %b required 1000", mv_vec()); end
    wait_idle("dbg");
  endtask

  task automatic test_back_to_back();
    dbg_wr_valid = 1'b1;
    dbg_wr_addr  = 4'd1;
    dbg_wr_data  = 4'd9;
    step();
    checks++; if (dbg_valid !== 1'b1 || dbg_addr !== 4'd1 || dbg_data !== 4'd9) begin
      errors++; $display("FAIL b2b_first: got v=%b a=%0d d=%0d required v=1 a=1 d=9", dbg_valid, dbg_addr, dbg_data); end
    dbg_wr_addr = 4'd2;
    dbg_wr_data = 4'd4;
    step();
    checks++; if (dbg_valid !== 1'b0 || dbg_wr_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got v=%b ready=%b required v=0 ready=1", dbg_valid, dbg_wr_ready); end
    step();
    dbg_wr_valid = 1'b0;
    checks++; if (dbg_valid !== 1'b1 || dbg_addr !== 4'd2 || dbg_data !== 4'd4) begin
      errors++; $display("FAIL b2b_second: got v=%b a=%0d d=%0d required v=1 a=2 d=4", dbg_valid, dbg_addr, dbg_data); end
    step();
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b required 0", dbg_valid); end
  endtask

  task automatic test_auto();
    auto_enable = 1'b1;
    auto_valid  = 1'b1;
    auto_dir    = 2'd3;
    btn_left    = 1'b1;
    #1;
    checks++; if (auto_ready !== 1'b0) begin errors++; $display("FAIL auto_blocked: got %b required 0", auto_ready); end
    exp_moves.push_back(0);
    step();
    btn_left = 1'b0;
    #1;
    checks++; if (auto_ready !== 1'b1) begin errors++; $display("FAIL auto_ready: got %b required 1", auto_ready); end
    exp_moves.push_back(3);
    step();
    auto_valid  = 1'b0;
    auto_enable = 1'b0;
    checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL auto_count: got %0d required 1", queue_count); end
    checks++; if (mv_vec() !== 4'b0001) begin errors++; $display("FAIL auto_first: got %b required 0001", mv_vec()); end
    wait_idle("auto");
  endtask

  task automatic test_reset_and_flush();
    press(0);
    step();               // MOVE
    press(1);
    press(2);
    press(3);
    checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL rst_pre_count: got %0d required 3", queue_count); end
    rst_n = 1'b0;
    exp_moves.delete();
    step();
    checks++; if (queue_count !== 3'd0 || mv_vec() !== 4'b0000 || overflow !== 1'b0 || dbg_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got count %0d moves %b ovf %b dbg %b required all 0",
                         queue_count, mv_vec(), overflow, dbg_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++; if (queue_count !== 3'd0 || dbg_wr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after: got count %0d ready %b required 0 1", queue_count, dbg_wr_ready); end

    press(0);
    step();               // MOVE
    press(1);
    press(2);
    step();
    checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL flush_pre_count: got %0d required 2", queue_count); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_moves.delete();
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d required 0", queue_count); end
    checks++; if (dbg_wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wait_kept: got ready %b required 0", dbg_wr_ready); end
    wait_idle("flush");
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    auto_enable = 1'b0; auto_valid = 1'b0; auto_dir = 2'd0;
    dbg_wr_valid = 1'b0; dbg_wr_addr = 4'd0; dbg_wr_data = 4'd0;
    flush = 1'b0; clr_overflow = 1'b0;

    test_reset();
    test_single_press();
    test_priority();
    test_overflow();
    test_dbg_during_wait();
    test_back_to_back();
    test_auto();
    test_reset_and_flush();

    checks++;
    if (exp_moves.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d moves outstanding required 0", exp_moves.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
